// File: rtl/bictr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bictr_seq_pkg
// Purpose  : Shared command-op and FSM state encodings for bictr_cmd_seq.
// Revision : 1.0 - initial release
// ============================================================================
package bictr_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DN   = 2'd2,
        OP_TC   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_TC   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bictr_seq_lencnt.sv
`default_nettype none
// ============================================================================
// Module   : bictr_seq_lencnt
// Purpose  : Loadable down-counter with zero flag; paces UP/DN length and TC timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bictr_seq_lencnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/bictr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bictr_cmd_seq
// Purpose  : Command sequencer driving a bidirectional count-to counter.
//            BICTR_SEQ_TC_TIMEOUT_EN enables the TC-operation timeout and err.
// Revision : 1.0 - initial release
// ============================================================================
module bictr_cmd_seq
    import bictr_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] data,
    output logic             up_dn,
    output logic             load,
    output logic             cen,
    input  logic             tercnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             up_dn_q, up_dn_d;
    logic             load_q, load_d;
    logic             cen_q, cen_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0] len_m1;
    op_e              op;

    assign op = op_e'(cmd_op);
    // Counter holds "cycles remaining after this one", so load len-1.
    assign len_m1 = (cmd_len == '0) ? '0 : (cmd_len - LEN_W'(1));

`ifdef BICTR_SEQ_TC_TIMEOUT_EN
    logic limit_q, limit_d;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        up_dn_d  = up_dn_q;
        load_d   = 1'b1;
        cen_d    = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef BICTR_SEQ_TC_TIMEOUT_EN
        limit_d  = limit_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                            load_d  = 1'b0;
                            data_d  = cmd_data;
                        end
                        OP_UP, OP_DN: begin
                            up_dn_d = (op == OP_UP);
                            if (cmd_len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d  = ST_RUN;
                                cen_d    = 1'b1;
                                cnt_load = 1'b1;
                            end
                        end
                        default: begin
                            state_d  = ST_TC;
                            up_dn_d  = cmd_data[0];
                            cnt_load = 1'b1;
`ifdef BICTR_SEQ_TC_TIMEOUT_EN
                            limit_d  = (cmd_len != '0);
`endif
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    cen_d   = 1'b1;
                end
            end
            default: begin
                if (tercnt) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
`ifdef BICTR_SEQ_TC_TIMEOUT_EN
                    if (limit_q && cnt_zero) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            up_dn_q <= 1'b1;
            load_q  <= 1'b1;
            cen_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            up_dn_q <= up_dn_d;
            load_q  <= load_d;
            cen_q   <= cen_d;
            done_q  <= done_d;
        end
    end

`ifdef BICTR_SEQ_TC_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            limit_q <= limit_d;
            err_q   <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    bictr_seq_lencnt #(
        .LEN_W (LEN_W)
    ) u_lencnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (cnt_load),
        .load_val (len_m1),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign data      = data_q;
    assign up_dn     = up_dn_q;
    assign load      = load_q;
    assign done      = done_q;
    // TC enable follows tercnt combinationally so the counter never steps past count_to.
    assign cen       = (state_q == ST_TC) ? !tercnt : cen_q;

endmodule
`default_nettype wire

// File: tb/tb_bictr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bictr_cmd_seq
// Purpose  : Directed self-checking bench for bictr_cmd_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bictr_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] cmd_len = 8'd0;
    logic [7:0] data;
    logic       up_dn, load, cen, busy, done, err;
    logic       tercnt = 1'b0;

    int checks = 0;
    int failures = 0;

    bictr_cmd_seq #(.WIDTH(8), .LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .data      (data),
        .up_dn     (up_dn),
        .load      (load),
        .cen       (cen),
        .tercnt    (tercnt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
    endtask

    task automatic drop();
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_data  = 8'hFF;
        cmd_len   = 8'hFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({cmd_ready, data, up_dn, load, cen, busy, done, err} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_vals got rdy=%b data=%h up=%b ld=%b cen=%b busy=%b done=%b err=%b exp 1 00 1 1 0 0 0 0",
                     cmd_ready, data, up_dn, load, cen, busy, done, err);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load();
        issue(2'd0, 8'h5A, 8'd0);
        step();
        drop();
        checks++;
        if ({load, data, cen, busy, cmd_ready} !== {1'b0, 8'h5A, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL load_c1 got ld=%b data=%h cen=%b busy=%b rdy=%b exp 0 5a 0 1 0", load, data, cen, busy, cmd_ready);
        end
        step();
        checks++;
        if ({done, cmd_ready, load, data} !== {1'b1, 1'b1, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL load_c2 got done=%b rdy=%b ld=%b data=%h exp 1 1 1 5a", done, cmd_ready, load, data);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL load_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd1, 8'h00, 8'd3);
        step();
        issue(2'd2, 8'h00, 8'd2);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({cen, up_dn, cmd_ready, load, done} !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL up3_c%0d got cen=%b up=%b rdy=%b ld=%b done=%b exp 1 1 0 1 0", i, cen, up_dn, cmd_ready, load, done);
            end
            step();
        end
        checks++;
        if ({done, cen, cmd_ready} !== {1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL up3_done got done=%b cen=%b rdy=%b exp 1 0 1", done, cen, cmd_ready);
        end
        step();
        drop();
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if ({cen, up_dn, done} !== {1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL dn2_c%0d got cen=%b up=%b done=%b exp 1 0 0", i, cen, up_dn, done);
            end
            step();
        end
        checks++;
        if ({done, cen, busy} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL dn2_done got done=%b cen=%b busy=%b exp 1 0 0", done, cen, busy);
        end
        step();
    endtask

    task automatic test_len0();
        issue(2'd1, 8'h00, 8'd0);
        step();
        drop();
        checks++;
        if ({done, cen, busy, cmd_ready, up_dn} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL len0 got done=%b cen=%b busy=%b rdy=%b up=%b exp 1 0 0 1 1", done, cen, busy, cmd_ready, up_dn);
        end
        step();
    endtask

    task automatic test_tc();
        tercnt = 1'b0;
        issue(2'd3, 8'h01, 8'd0);
        step();
        drop();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({cen, up_dn, busy, done} !== {1'b1, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL tc_c%0d got cen=%b up=%b busy=%b done=%b exp 1 1 1 0", i, cen, up_dn, busy, done);
            end
            step();
        end
        tercnt = 1'b1;
        #1;
        checks++;
        if ({cen, busy, done} !== {1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL tc_c4 got cen=%b busy=%b done=%b exp 0 1 0", cen, busy, done);
        end
        step();
        checks++;
        if ({done, cen, err, cmd_ready} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL tc_done got done=%b cen=%b err=%b rdy=%b exp 1 0 0 1", done, cen, err, cmd_ready);
        end
        // tercnt already high at entry, direction down
        issue(2'd3, 8'h00, 8'd0);
        step();
        drop();
        checks++;
        if ({cen, up_dn, busy} !== {1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL tc_entry got cen=%b up=%b busy=%b exp 0 0 1", cen, up_dn, busy);
        end
        step();
        checks++;
        if ({done, cen} !== {1'b1, 1'b0}) begin
            failures++;
            $display("FAIL tc_entry_done got done=%b cen=%b exp 1 0", done, cen);
        end
        tercnt = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        tercnt = 1'b0;
        issue(2'd3, 8'h01, 8'd5);
        step();
        drop();
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if ({cen, err, done} !== {1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL to_c%0d got cen=%b err=%b done=%b exp 1 0 0", i, cen, err, done);
            end
            step();
        end
`ifdef BICTR_SEQ_TC_TIMEOUT_EN
        checks++;
        if ({cen, done, err, busy} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL to_abort got cen=%b done=%b err=%b busy=%b exp 0 1 1 0", cen, done, err, busy);
        end
        step();
        checks++;
        if ({done, err} !== {1'b0, 1'b0}) begin
            failures++;
            $display("FAIL to_pulse got done=%b err=%b exp 0 0", done, err);
        end
`else
        for (int i = 6; i <= 8; i++) begin
            checks++;
            if ({cen, err, done, busy} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL to_wait_c%0d got cen=%b err=%b done=%b busy=%b exp 1 0 0 1", i, cen, err, done, busy);
            end
            step();
        end
        tercnt = 1'b1;
        step();
        checks++;
        if ({done, err} !== {1'b1, 1'b0}) begin
            failures++;
            $display("FAIL to_end got done=%b err=%b exp 1 0", done, err);
        end
        tercnt = 1'b0;
`endif
        step();
    endtask

    task automatic test_max_len();
        int cen_cycles;
        int done_at;
        cen_cycles = 0;
        done_at = 0;
        issue(2'd1, 8'h00, 8'd255);
        step();
        drop();
        for (int i = 1; i <= 300 && done_at == 0; i++) begin
            if (cen) cen_cycles++;
            if (done) done_at = i;
            step();
        end
        checks++;
        if (cen_cycles !== 255 || done_at !== 256) begin
            failures++;
            $display("FAIL max_len got cen_cycles=%0d done_cycle=%0d exp 255 256", cen_cycles, done_at);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        issue(2'd1, 8'h00, 8'd10);
        step();
        drop();
        step();
        checks++;
        if (cen !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre got cen=%b exp 1", cen);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, data, up_dn, load, cen, busy, done, err} !== {1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} && data !== 8'h00) begin
            failures++;
            $display("FAIL rmid_async got rdy=%b data=%h up=%b ld=%b cen=%b busy=%b done=%b err=%b", cmd_ready, data, up_dn, load, cen, busy, done, err);
        end
        checks++;
        if ({cmd_ready, data, up_dn, load, cen, busy, done, err} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rmid_vals got rdy=%b data=%h up=%b ld=%b cen=%b busy=%b done=%b err=%b exp 1 00 1 1 0 0 0 0",
                     cmd_ready, data, up_dn, load, cen, busy, done, err);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || cen || busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL rmid_after got active_cycles=%0d exp 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_len0();
        test_tc();
        test_timeout();
        test_max_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bictr_cmd_seq.md
# bictr_cmd_seq

Command sequencer sitting directly upstream of the bidirectional static-count-to counter. Accepts load/count commands over a valid/ready handshake and drives the counter's `data`, `up_dn`, `load` and `cen` inputs cycle by cycle. It also observes the counter's `tercnt` output to run "count until terminal" operations, so software-level control reduces to short command words.

## Interface
- `width`, 8: counter data width; must match the downstream counter.
- `len_w`, 8: width of the cycle-count field in a command.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  2: 0 LOAD, 1 UP, 2 DN, 3 TC.
- `cmd_data`  in  width: LOAD value; for TC, bit 0 selects direction (1 = up).
- `cmd_len`  in  len_w: active cycles for UP/DN; timeout for TC (see Configuration).
- `data`  out  width: to counter `data`.
- `up_dn`  out  1: to counter `up_dn` (1 = up).
- `load`  out  1: to counter `load`, active-low.
- `cen`  out  1: to counter `cen`, active-high.
- `tercnt`  in  1: from counter; combinational count == count_to.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle TC-timeout pulse.

## Operation
- States: IDLE, LOAD, RUN, TC. `cmd_ready` = (state == IDLE). `busy` = !IDLE.
- Handshake: accept on the rising edge with `cmd_valid && cmd_ready`. `cmd_*` is registered at acceptance and may change afterwards.
- LOAD: one cycle with `load`=0, `cen`=0 and `data`=cmd_data, then IDLE.
- UP/DN: `up_dn`=1 or 0, `cen`=1 for exactly cmd_len cycles, then IDLE. cmd_len=0 → zero `cen` cycles; goes straight to IDLE with `done`.
- TC: `up_dn`=cmd_data[0]. `cen` = !tercnt (combinational, so the counter stops holding count_to). Exit to IDLE in the first cycle where `tercnt`=1. If `tercnt` is already 1 on entry, there are zero `cen` cycles.
- `data` is registered and holds its last LOAD value in all other states.
- Other outputs are driven registered, except TC-state `cen`.
- `done` pulses in the first IDLE cycle after any completed command. A new command may be accepted in that same cycle.
- `load` and `cen` are never active in the same cycle.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `data`=0, `up_dn`=1, `load`=1, `cen`=0, `busy`=0, `done`=0, `err`=0.
- Latency: accept at edge 0 → first active cycle is cycle 1.
  - UP/DN with len N: `cen` high in cycles 1..N; `done` in cycle N+1.
  - LOAD: `load`=0 in cycle 1; `done` in cycle 2.
- Back-to-back: a command accepted in a `done` cycle starts in the next cycle. Minimum command period is 2 cycles.
- Length countdown is len_w bits; cmd_len = 2^len_w−1 is the maximum and must not wrap.
- Reset mid-command: abort at once and deassert `cen`/`load` asynchronously. No `done` is produced.

## Configuration
- `BICTR_SEQ_TC_TIMEOUT_EN` defined:
  - TC with cmd_len>0 aborts after cmd_len `cen` cycles without `tercnt`.
  - On abort, `cen` drops and `done` and `err` pulse together.
  - cmd_len=0 means no limit.
- Undefined:
  - `err` is tied 0.
  - cmd_len is ignored for TC, which waits indefinitely.

## Structure
- Shared package `bictr_seq_pkg`: op encoding enum (LOAD/UP/DN/TC), FSM state enum.
- One sub-module, `bictr_seq_lencnt`: loadable len_w down-counter with zero flag. It is used for UP/DN length and the TC timeout.

## Test plan
- Reset, then LOAD 0x5A → cycle 1: `load`=0, `data`=0x5A, `cen`=0; cycle 2: `done`=1, `cmd_ready`=1.
- UP len 3 with `cmd_valid` held high carrying DN len 2 → `cen`=1 with `up_dn`=1 for 3 cycles; `done`; then `cen`=1 with `up_dn`=0 for 2 cycles; `done`.
- UP len 0 → no `cen` cycle; `done` in cycle 1.
- TC up with `tercnt` rising in the 4th cycle → `cen`=1 for 3 cycles, 0 in the 4th; `done` in the 5th. With `tercnt`=1 at entry → `cen` never rises.
- With macro: TC len 5 and `tercnt` stuck 0 → 5 `cen` cycles, then `done`=`err`=1. Without macro: `cen` stays 1 and `err` stays 0.
- Assert `reset` during the 2nd `cen` cycle of UP len 10 → `cen`=0 immediately, all outputs at reset values, no `done`.
